// File: rtl/video_pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// video_pll_reset_sequencer
//
// Brings up a video PLL and the logic it clocks. The PLL is held in reset for
// a fixed pulse, then the sequencer waits for lock. Lock must be held without
// interruption for a stable period before video-domain reset is released. A
// wait that never sees lock times out and re-pulses the PLL; a lock loss while
// running re-pulses the PLL and re-asserts video reset.
//
// Ports
//   refclk        in   single 50 MHz clock, all logic on its rising edge
//   rst           in   synchronous active-high reset
//   pll_locked    in   PLL lock indication, asynchronous to refclk
//   pll_rst       out  reset to the PLL, active-high (registered)
//   video_rst     out  reset to video-domain logic, active-high (registered)
//   lock_ok       out  high only while running (registered)
//   retry_count   out  saturating count of lock-wait timeouts
//   relock_count  out  saturating count of lock losses while running
//   state         out  0=PLL_RST 1=WAIT_LOCK 2=STABLE 3=RUN
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module video_pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 1000000
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       video_rst,
  output logic       lock_ok,
  output logic [7:0] retry_count,
  output logic [7:0] relock_count,
  output logic [1:0] state
);

  // One counter serves every state; 24 bits covers the largest timeout.
  localparam int CNT_W = 24;
  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             pll_rst_q, pll_rst_d;
  logic             video_rst_q, video_rst_d;
  logic             lock_ok_q, lock_ok_d;
  logic [7:0]       retry_q, retry_d;
  logic [7:0]       relock_q, relock_d;
  logic             locked_sync;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign locked_sync = sync2_q;

  always_comb begin
    sync1_d  = pll_locked;
    sync2_d  = sync1_q;
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    retry_d  = retry_q;
    relock_d = relock_q;

    case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == PLL_RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (locked_sync) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = ST_PLL_RST;
          retry_d = sat_inc(retry_q);
        end
      end
      ST_STABLE: begin
        // A dropout restarts the whole wait, including the timeout window.
        if (!locked_sync) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!locked_sync) begin
          state_d  = ST_PLL_RST;
          relock_d = sat_inc(relock_q);
        end
      end
      default: state_d = ST_PLL_RST;
    endcase

    if (state_d != state_q) cnt_d = '0;

    // Outputs decoded from the next state so they register on the same edge.
    pll_rst_d   = (state_d == ST_PLL_RST);
    video_rst_d = (state_d != ST_RUN);
    lock_ok_d   = (state_d == ST_RUN);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= ST_PLL_RST;
      cnt_q       <= '0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      pll_rst_q   <= 1'b1;
      video_rst_q <= 1'b1;
      lock_ok_q   <= 1'b0;
      retry_q     <= 8'd0;
      relock_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      pll_rst_q   <= pll_rst_d;
      video_rst_q <= video_rst_d;
      lock_ok_q   <= lock_ok_d;
      retry_q     <= retry_d;
      relock_q    <= relock_d;
    end
  end

  assign pll_rst      = pll_rst_q;
  assign video_rst    = video_rst_q;
  assign lock_ok      = lock_ok_q;
  assign retry_count  = retry_q;
  assign relock_count = relock_q;
  assign state        = state_q;

endmodule
